// File: rtl/subckt_power_probe.sv
// subckt_power_probe
// Drives a 4-input combinational sub-circuit with an LFSR vector sequence,
// compacts its 1-bit response into a 16-bit MISR signature, and counts
// input and output toggles as a switching-activity proxy.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stim held at 0, results from the last run held, waiting start
// RUN   | one vector per cycle; resp of the driven vector sampled
// DONE  | one-cycle done pulse, busy low, then back to IDLE

module subckt_power_probe #(
  parameter int unsigned NUM_VEC   = 256,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [3:0]       stim,
  input  logic             resp,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [15:0]      signature,
  output logic [CNT_W-1:0] in_toggles,
  output logic [CNT_W-1:0] out_toggles,
  output logic [15:0]      vec_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] LAST_VEC = 16'(NUM_VEC - 1);

  state_e           state_q;
  logic [15:0]      lfsr_q;
  logic [3:0]       stim_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic [15:0]      sig_q;
  logic [CNT_W-1:0] in_tog_q;
  logic [CNT_W-1:0] out_tog_q;
  logic [15:0]      vec_q;
  logic             prev_resp_q;

  logic [15:0]      lfsr_d;
  logic [15:0]      sig_d;
  logic [CNT_W-1:0] in_tog_d;
  logic [CNT_W-1:0] out_tog_d;
  logic [CNT_W-1:0] in_tog_seed;
  logic             last_vec;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Counters stick at all-ones instead of wrapping; the extra top bit of
  // the sum is the overflow indicator.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [2:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    if (s[CNT_W]) return '1;
    return s[CNT_W-1:0];
  endfunction

  // Next-value datapath: LFSR step, MISR step and saturating toggle sums.
  always_comb begin
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    sig_d       = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                  ^ {15'b0, resp};
    in_tog_d    = sat_add(in_tog_q, pop4(stim_q ^ lfsr_d[3:0]));
    out_tog_d   = sat_add(out_tog_q, {2'b00, resp ^ prev_resp_q});
    in_tog_seed = sat_add('0, pop4(LFSR_SEED[3:0]));
    last_vec    = (vec_q == LAST_VEC);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= '0;
      stim_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      sig_q       <= '0;
      in_tog_q    <= '0;
      out_tog_q   <= '0;
      vec_q       <= '0;
      prev_resp_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            lfsr_q      <= LFSR_SEED;
            stim_q      <= LFSR_SEED[3:0];
            sig_q       <= '0;
            // Vector 0 already flips bits relative to the idle value 0.
            in_tog_q    <= in_tog_seed;
            out_tog_q   <= '0;
            vec_q       <= '0;
            prev_resp_q <= 1'b0;
            aborted_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            // Current resp is discarded; partial results stay visible.
            stim_q    <= '0;
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            sig_q       <= sig_d;
            out_tog_q   <= out_tog_d;
            prev_resp_q <= resp;
            vec_q       <= vec_q + 16'd1;
            if (last_vec) begin
              stim_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              lfsr_q   <= lfsr_d;
              stim_q   <= lfsr_d[3:0];
              in_tog_q <= in_tog_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stim        = stim_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign signature   = sig_q;
  assign in_toggles  = in_tog_q;
  assign out_toggles = out_tog_q;
  assign vec_count   = vec_q;

endmodule

// File: tb/tb_subckt_power_probe.sv
// Directed bench for subckt_power_probe: four instances cover NUM_VEC=1,
// NUM_VEC=2, the full 256-vector run and a narrow-counter saturation case.

module tb_subckt_power_probe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: NUM_VEC=1, resp tied 0
  logic        start_a = 0, abort_a = 0, resp_a = 0;
  logic [3:0]  stim_a;
  logic        busy_a, done_a, aborted_a;
  logic [15:0] sig_a, vec_a;
  logic [19:0] in_a, out_a;

  // Instance B: NUM_VEC=2, resp tied 1
  logic        start_b = 0, abort_b = 0, resp_b = 1;
  logic [3:0]  stim_b;
  logic        busy_b, done_b, aborted_b;
  logic [15:0] sig_b, vec_b;
  logic [19:0] in_b, out_b;

  // Instance M: NUM_VEC=256, resp from the reference sub-circuit
  logic        start_m = 0, abort_m = 0;
  logic        resp_m;
  logic [3:0]  stim_m;
  logic        busy_m, done_m, aborted_m;
  logic [15:0] sig_m, vec_m;
  logic [19:0] in_m, out_m;
  assign resp_m = stim_m[2] & stim_m[3] & ~(stim_m[0] ^ stim_m[1]);

  // Instance S: NUM_VEC=16, CNT_W=3, resp toggling every cycle
  logic        start_s = 0, abort_s = 0, resp_s = 0;
  logic [3:0]  stim_s;
  logic        busy_s, done_s, aborted_s;
  logic [15:0] sig_s, vec_s;
  logic [2:0]  in_s, out_s;
  always @(negedge clk) resp_s <= ~resp_s;

  subckt_power_probe #(.NUM_VEC(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .stim(stim_a),
    .resp(resp_a), .busy(busy_a), .done(done_a), .aborted(aborted_a),
    .signature(sig_a), .in_toggles(in_a), .out_toggles(out_a), .vec_count(vec_a));

  subckt_power_probe #(.NUM_VEC(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .stim(stim_b),
    .resp(resp_b), .busy(busy_b), .done(done_b), .aborted(aborted_b),
    .signature(sig_b), .in_toggles(in_b), .out_toggles(out_b), .vec_count(vec_b));

  subckt_power_probe #(.NUM_VEC(256)) u_m (
    .clk(clk), .rst_n(rst_n), .start(start_m), .abort(abort_m), .stim(stim_m),
    .resp(resp_m), .busy(busy_m), .done(done_m), .aborted(aborted_m),
    .signature(sig_m), .in_toggles(in_m), .out_toggles(out_m), .vec_count(vec_m));

  subckt_power_probe #(.NUM_VEC(16), .CNT_W(3)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s), .stim(stim_s),
    .resp(resp_s), .busy(busy_s), .done(done_s), .aborted(aborted_s),
    .signature(sig_s), .in_toggles(in_s), .out_toggles(out_s), .vec_count(vec_s));

  // Reference model results
  logic [3:0]  exp_stim [0:255];
  logic [15:0] exp_sig, exp_sig10;
  int          exp_in, exp_out, exp_in10, exp_out10, exp_in16;

  task automatic compute_model();
    logic [15:0] lfsr, sig;
    logic [3:0]  st;
    logic        r, prev, fb;
    int          in_t, out_t;
    lfsr  = 16'hACE1;
    st    = lfsr[3:0];
    in_t  = $countones(st);
    out_t = 0;
    sig   = 16'h0000;
    prev  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      exp_stim[i] = st;
      if (i == 10) exp_sig10 = sig;
      r  = st[2] & st[3] & ~(st[0] ^ st[1]);
      fb = sig[15];
      sig = {sig[14:0], 1'b0};
      if (fb) sig = sig ^ 16'h1021;
      sig[0] = sig[0] ^ r;
      if (r != prev) out_t++;
      prev = r;
      if (i < 255) begin
        fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        lfsr = {lfsr[14:0], fb};
        in_t = in_t + $countones(st ^ lfsr[3:0]);
        st   = lfsr[3:0];
      end
      if (i == 9) begin
        exp_in10  = in_t;
        exp_out10 = out_t;
      end
      if (i == 14) exp_in16 = in_t;
    end
    exp_sig = sig;
    exp_in  = in_t;
    exp_out = out_t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 1; start_b = 1; start_m = 1; start_s = 1;
    repeat (3) step();
    n_vec++; if (stim_m !== 4'h0) begin n_err++; $display("FAIL reset_stim: got %h expected 0", stim_m); end
    n_vec++; if (busy_m !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_m); end
    n_vec++; if (done_m !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done_m); end
    n_vec++; if (aborted_m !== 1'b0) begin n_err++; $display("FAIL reset_aborted: got %b expected 0", aborted_m); end
    n_vec++; if (sig_m !== 16'h0) begin n_err++; $display("FAIL reset_sig: got %h expected 0", sig_m); end
    n_vec++; if ({in_m, out_m, vec_m} !== 56'h0) begin n_err++; $display("FAIL reset_counts: got %h expected 0", {in_m, out_m, vec_m}); end
    n_vec++;
    if ({stim_a, busy_a, stim_b, busy_b, stim_s, busy_s, sig_s, out_s} !== 37'h0) begin
      n_err++; $display("FAIL reset_other: got %h expected 0",
                        {stim_a, busy_a, stim_b, busy_b, stim_s, busy_s, sig_s, out_s});
    end
    start_a = 0; start_b = 0; start_s = 0;
    rst_n = 1'b1;
    step();
    start_m = 0;
    n_vec++; if (stim_m !== 4'h1) begin n_err++; $display("FAIL first_stim: got %h expected 1", stim_m); end
    n_vec++; if (busy_m !== 1'b1) begin n_err++; $display("FAIL first_busy: got %b expected 1", busy_m); end
    begin
      int cyc;
      cyc = 0;
      while (done_m !== 1'b1 && cyc < 400) begin step(); cyc++; end
      n_vec++; if (done_m !== 1'b1) begin n_err++; $display("FAIL first_run_timeout: done %b expected 1", done_m); end
    end
    step();
  endtask

  task automatic test_single_vector();
    start_a = 1;
    step();
    start_a = 0;
    n_vec++; if ({busy_a, stim_a, done_a} !== 6'b1_0001_0) begin n_err++; $display("FAIL nv1_start: got busy/stim/done %b expected 1_0001_0", {busy_a, stim_a, done_a}); end
    step();
    n_vec++; if ({done_a, busy_a, stim_a} !== 6'b1_0_0000) begin n_err++; $display("FAIL nv1_done: got done/busy/stim %b expected 1_0_0000", {done_a, busy_a, stim_a}); end
    n_vec++; if (sig_a !== 16'h0000) begin n_err++; $display("FAIL nv1_sig: got %h expected 0000", sig_a); end
    n_vec++; if (in_a !== 20'd1 || out_a !== 20'd0) begin n_err++; $display("FAIL nv1_toggles: got in %0d out %0d expected in 1 out 0", in_a, out_a); end
    n_vec++; if (vec_a !== 16'd1) begin n_err++; $display("FAIL nv1_vec: got %0d expected 1", vec_a); end
    step();
    n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL nv1_done_pulse: got %b expected 0", done_a); end
  endtask

  task automatic test_two_vectors();
    start_b = 1;
    step();
    start_b = 0;
    n_vec++; if (stim_b !== 4'h1) begin n_err++; $display("FAIL nv2_stim0: got %h expected 1", stim_b); end
    step();
    n_vec++; if (stim_b !== 4'h3 || done_b !== 1'b0) begin n_err++; $display("FAIL nv2_stim1: got stim %h done %b expected 3 0", stim_b, done_b); end
    step();
    n_vec++; if (done_b !== 1'b1 || stim_b !== 4'h0) begin n_err++; $display("FAIL nv2_done: got done %b stim %h expected 1 0", done_b, stim_b); end
    n_vec++; if (sig_b !== 16'h0003) begin n_err++; $display("FAIL nv2_sig: got %h expected 0003", sig_b); end
    n_vec++; if (in_b !== 20'd2 || out_b !== 20'd1 || vec_b !== 16'd2) begin n_err++; $display("FAIL nv2_counts: got in %0d out %0d vec %0d expected 2 1 2", in_b, out_b, vec_b); end
    step();
  endtask

  // Assumes start_m was just accepted (stim_m shows vector 0).
  task automatic check_full_run(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (stim_m !== exp_stim[i] || busy_m !== 1'b1) bad++;
      step();
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL %s_stim_seq: got %0d bad vectors expected 0", tag, bad); end
    n_vec++; if (done_m !== 1'b1 || busy_m !== 1'b0 || stim_m !== 4'h0) begin n_err++; $display("FAIL %s_done: got done %b busy %b stim %h expected 1 0 0", tag, done_m, busy_m, stim_m); end
    n_vec++; if (sig_m !== exp_sig) begin n_err++; $display("FAIL %s_sig: got %h expected %h", tag, sig_m, exp_sig); end
    n_vec++; if (in_m !== 20'(exp_in)) begin n_err++; $display("FAIL %s_in_toggles: got %0d expected %0d", tag, in_m, exp_in); end
    n_vec++; if (out_m !== 20'(exp_out)) begin n_err++; $display("FAIL %s_out_toggles: got %0d expected %0d", tag, out_m, exp_out); end
    n_vec++; if (vec_m !== 16'd256) begin n_err++; $display("FAIL %s_vec: got %0d expected 256", tag, vec_m); end
  endtask

  task automatic test_model_run();
    start_m = 1;
    step();
    start_m = 0;
    check_full_run("run1");
  endtask

  task automatic test_back_to_back();
    step();
    n_vec++; if (done_m !== 1'b0) begin n_err++; $display("FAIL b2b_done_pulse: got %b expected 0", done_m); end
    n_vec++; if (sig_m !== exp_sig) begin n_err++; $display("FAIL b2b_held_sig: got %h expected %h", sig_m, exp_sig); end
    start_m = 1;
    step();
    start_m = 0;
    check_full_run("run2");
    step();
  endtask

  task automatic test_saturation();
    int cyc;
    start_s = 1;
    step();
    start_s = 0;
    cyc = 0;
    while (done_s !== 1'b1 && cyc < 40) begin step(); cyc++; end
    n_vec++; if (done_s !== 1'b1) begin n_err++; $display("FAIL sat_timeout: done %b expected 1", done_s); end
    n_vec++; if (out_s !== 3'd7) begin n_err++; $display("FAIL sat_out_toggles: got %0d expected 7", out_s); end
    n_vec++; if (in_s !== ((exp_in16 > 7) ? 3'd7 : 3'(exp_in16))) begin n_err++; $display("FAIL sat_in_toggles: got %0d expected min(%0d,7)", in_s, exp_in16); end
    n_vec++; if (vec_s !== 16'd16) begin n_err++; $display("FAIL sat_vec: got %0d expected 16", vec_s); end
    step();
  endtask

  task automatic test_abort();
    int seen_done;
    start_m = 1;
    step();
    start_m = 0;
    repeat (10) step();
    n_vec++; if (vec_m !== 16'd10 || stim_m !== exp_stim[10]) begin n_err++; $display("FAIL abort_pre: got vec %0d stim %h expected 10 %h", vec_m, stim_m, exp_stim[10]); end
    abort_m = 1;
    start_m = 1;
    step();
    abort_m = 0;
    start_m = 0;
    n_vec++; if (aborted_m !== 1'b1 || busy_m !== 1'b0) begin n_err++; $display("FAIL abort_flag: got aborted %b busy %b expected 1 0", aborted_m, busy_m); end
    n_vec++; if (vec_m !== 16'd10 || stim_m !== 4'h0) begin n_err++; $display("FAIL abort_state: got vec %0d stim %h expected 10 0", vec_m, stim_m); end
    n_vec++; if (sig_m !== exp_sig10) begin n_err++; $display("FAIL abort_sig: got %h expected %h", sig_m, exp_sig10); end
    n_vec++; if (in_m !== 20'(exp_in10) || out_m !== 20'(exp_out10)) begin n_err++; $display("FAIL abort_toggles: got in %0d out %0d expected %0d %0d", in_m, out_m, exp_in10, exp_out10); end
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_m === 1'b1 || busy_m === 1'b1) seen_done++;
      step();
    end
    n_vec++; if (seen_done != 0) begin n_err++; $display("FAIL abort_no_done: got %0d done/busy cycles expected 0", seen_done); end
    n_vec++; if (aborted_m !== 1'b1 || vec_m !== 16'd10) begin n_err++; $display("FAIL abort_hold: got aborted %b vec %0d expected 1 10", aborted_m, vec_m); end
    start_m = 1;
    step();
    start_m = 0;
    n_vec++; if (aborted_m !== 1'b0 || busy_m !== 1'b1 || vec_m !== 16'd0) begin n_err++; $display("FAIL abort_restart: got aborted %b busy %b vec %0d expected 0 1 0", aborted_m, busy_m, vec_m); end
  endtask

  // Main instance is still running from the restart in test_abort.
  task automatic test_reset_mid_run();
    int seen;
    repeat (5) step();
    n_vec++; if (busy_m !== 1'b1 || vec_m !== 16'd5) begin n_err++; $display("FAIL midrun_pre: got busy %b vec %0d expected 1 5", busy_m, vec_m); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({stim_m, busy_m, done_m, aborted_m, sig_m, in_m, out_m, vec_m} !== 63'h0) begin
      n_err++; $display("FAIL midrun_reset: got %h expected 0",
                        {stim_m, busy_m, done_m, aborted_m, sig_m, in_m, out_m, vec_m});
    end
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done_m !== 1'b0 || busy_m !== 1'b0) seen++;
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL midrun_after: got %0d active cycles expected 0", seen); end
  endtask

  initial begin
    compute_model();
    #1;
    test_reset();
    test_single_vector();
    test_two_vectors();
    test_model_run();
    test_back_to_back();
    test_saturation();
    test_abort();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/subckt_power_probe.md
# subckt_power_probe

Stimulus driver and response compactor for the 4-input, 1-output power sub-circuits. It drives the sub-circuit inputs with a pseudo-random vector sequence and compacts the 1-bit response into a 16-bit MISR signature, so that original and rewritten circuits can be compared. It also counts input-bit and output toggles as a switching-activity (power) proxy. It sits between the experiment controller (start/abort/results) and the combinational sub-circuit under test.

## Interface
Parameters:
- NUM_VEC, 256, vectors applied per run; legal range 1..65535
- LFSR_SEED, 16'hACE1, nonzero LFSR load value at start
- CNT_W, 20, width of the toggle counters

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a run; sampled only in IDLE
- abort  input  1  end a run early; sampled only in RUN
- stim  output  4  vector to the sub-circuit: stim[0]→n_1, stim[1]→n_2, stim[2]→n_3, stim[3]→n_4; registered
- resp  input  1  sub-circuit output (n_8); combinational function of stim
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when a run completes normally
- aborted  output  1  sticky; set by abort, cleared by the next accepted start
- signature  output  16  MISR result
- in_toggles  output  CNT_W  total stim bit flips over the run
- out_toggles  output  CNT_W  total resp value changes over the run
- vec_count  output  16  vectors sampled so far in the run

## Operation
- States: IDLE, RUN, DONE.
- Reset: asynchronous clear of all registers. State=IDLE; stim=0, busy=0, done=0, aborted=0, signature=0, in_toggles=0, out_toggles=0, vec_count=0, lfsr=0, prev_resp=0.
- **IDLE.** stim=0.
  - start=1: lfsr←LFSR_SEED, stim←LFSR_SEED[3:0], signature, counters and prev_resp←0, aborted←0, go to RUN.
  - in_toggles is preloaded with popcount(LFSR_SEED[3:0]), i.e. the flips relative to the idle value 0.
- **RUN**, every cycle:
  - Sample resp for the current stim.
  - signature ← {signature[14:0],1'b0} ^ (signature[15] ? 16'h1021 : 0) ^ {15'b0,resp}.
  - out_toggles += (resp != prev_resp); prev_resp ← resp.
  - vec_count += 1.
  - If this was vector NUM_VEC-1: stim←0 and go to DONE.
  - Otherwise: advance the LFSR and set stim←lfsr_next[3:0]. in_toggles += popcount(stim ^ lfsr_next[3:0]).
- **LFSR.** 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. lfsr_next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- **DONE.** done=1 for exactly one cycle, busy=0, then IDLE.
- **Results.** signature, toggle counters and vec_count hold their values in IDLE until the next accepted start.
- **abort in RUN.**
  - The resp of the current cycle is not sampled.
  - stim←0, aborted←1, go to IDLE; done is not asserted.
  - Partial results are held.
- start and abort in the same RUN cycle: abort wins, start is ignored.
- start outside IDLE is ignored; abort outside RUN is ignored.
- **Toggle counters** saturate at all-ones and do not wrap.
- **Reset mid-run:** immediate return to the reset state; no done pulse.

## Timing
- start sampled at edge k: busy=1 and stim=vector 0 from edge k onward.
- Vector i is driven after edge k+i and its resp is sampled at edge k+i+1.
- done is high from edge k+NUM_VEC to edge k+NUM_VEC+1. Start-to-done latency is NUM_VEC+1 edges.
- stim returns to 0 in the same cycle done rises.
- busy falls in the done cycle.
- start may be reasserted in the cycle after done; back-to-back runs therefore have a 1-cycle gap.
- resp must settle within one cycle of a stim change. There is no combinational path from resp to any output.

## Test plan
- Reset with start=1 held: all outputs 0. Release rst_n, hold start 1 cycle → stim=4'h1, busy=1 on the next edge.
- NUM_VEC=1, resp tied 0 → done after 2 edges; signature=16'h0000, out_toggles=0, in_toggles=1, vec_count=1.
- NUM_VEC=2, resp tied 1 → stim sequence 4'h1 then 4'h3; signature=16'h0003, out_toggles=1, in_toggles=2, vec_count=2.
- NUM_VEC=256, resp driven by the model n_3&n_4&(n_1 XNOR n_2):
  - signature and both toggle counts match the reference model;
  - a second run started right after done gives an identical signature.
- abort asserted at vector 10 of 256 → no done pulse, aborted=1, vec_count=10, stim=0. The next start clears aborted.
- rst_n asserted mid-run → all outputs 0 immediately (asynchronously). CNT_W=3 with resp toggling every vector → out_toggles saturates at 7.
